uart_tx_scheduler: RTL and testbench
====================================

# uart_tx_scheduler

Controller that shares the single UART transmitter between two on-chip requesters: port A (ALU results, up to 2 bytes) and port B (register-file reads, up to 2 bytes). It arbitrates round-robin, latches the winning word, and sequences it LSB-byte-first into the transmitter's `p_data`/`data_valid` inputs. It paces itself on the transmitter's `BUSY` output. It sits between system control and `uart_TX` in the TX clock domain.

## Interface
Parameters:
- `WORD_W`, 16, requester word width; must be 8 or 16.
- `WD_CYCLES`, 8, watchdog limit in cycles; only used with `UART_TX_SCHED_WDOG_EN`.

Ports:
- `clk`  in  1  single clock for the block.
- `rst`  in  1  synchronous, active-low reset.
- `req_a`  in  1  request from port A; level, held until `gnt_a`.
- `data_a`  in  WORD_W  port A word; sampled at grant.
- `two_a`  in  1  1 sends both bytes, 0 sends `data_a[7:0]` only. Forced 0 when WORD_W=8.
- `gnt_a`  out  1  one-cycle grant pulse to port A.
- `req_b`, `data_b`, `two_b`, `gnt_b`: identical behaviour for port B.
- `tx_busy`  in  1  `BUSY` from the transmitter.
- `tx_p_data`  out  8  byte to the transmitter.
- `tx_data_valid`  out  1  one-cycle start pulse to the transmitter.
- `sched_busy`  out  1  high whenever state ≠ IDLE.
- `err_timeout`  out  1  sticky watchdog error flag.

## Operation
- States: IDLE, SEND, WAIT_HI, WAIT_LO, ABORT. ABORT exists only with the macro.
- IDLE:
  - A grant occurs only when `tx_busy`=0 and at least one request is high.
  - The arbiter picks the winner.
  - On that edge: the word and `two_x` are latched, the byte index is set to 0, `gnt_x`=1 for the next cycle, and the FSM moves to SEND.
- Arbitration:
  - Round-robin using a 1-bit `last` pointer; reset value is B, so A wins the first contention.
  - A lone request always wins.
  - The pointer updates only on a grant.
- SEND:
  - `tx_data_valid`=1 for exactly this one cycle.
  - `tx_p_data` = byte[idx].
  - Next state is WAIT_HI.
- WAIT_HI: wait for `tx_busy`=1, then go to WAIT_LO.
- WAIT_LO: wait for `tx_busy`=0. Then:
  - If idx=0 and two=1: idx becomes 1, go to SEND.
  - Otherwise: go to IDLE.
- `tx_p_data` is registered and held stable from SEND until the transmitter's `tx_busy` falls, because the transmitter computes parity combinationally from `p_data`.
  - In IDLE it holds its last value; after reset it is 0.
- Requests arriving while the FSM is not in IDLE are ignored until it returns to IDLE. Requesters must hold `req` until they see their grant.
- Simultaneous `req_a` and `req_b` in IDLE: exactly one grant; the loser is granted on the next IDLE pass.

## Timing
- Reset (rst=0 at a clock edge): state=IDLE, `last`=B, all outputs 0, `err_timeout`=0.
  - Reset mid-frame aborts immediately. `tx_data_valid` is never asserted during reset.
- Latency from `req` high in IDLE:
  - `gnt` at cycle +1.
  - `tx_data_valid` at cycle +1 (same cycle as the grant; SEND is entered on the grant edge).
- Between bytes: the second SEND is one cycle after the `tx_busy` fall is sampled.
- Back-to-back transfers: IDLE lasts at least one cycle between transfers. The next grant is earliest one cycle after return to IDLE.
- `gnt_x` is never high for two consecutive cycles.

## Configuration
- `UART_TX_SCHED_WDOG_EN` defined:
  - A counter runs in WAIT_HI and WAIT_LO and clears on each state entry.
  - If it reaches WD_CYCLES in WAIT_HI, or 16×11×WD_CYCLES in WAIT_LO:
    - the FSM goes to ABORT for one cycle, then IDLE;
    - any remaining byte is dropped;
    - `err_timeout` is set.
  - `err_timeout` clears only on reset.
- Undefined: no counter and no ABORT state; `err_timeout` is tied to 0; the FSM waits indefinitely.

## Structure
- Shared package `uart_tx_sched_pkg`:
  - state enum;
  - port index constants (PORT_A=0, PORT_B=1);
  - byte-width constant 8.
- Sub-module `tx_rr_arb`: 2-input round-robin arbiter. Inputs: req[1:0], grant_en. Outputs: one-hot gnt. It holds the `last` pointer internally.

## Test plan
- Single port A, two_a=1, data_a=16'hA55A:
  - `gnt_a` one pulse;
  - `tx_p_data`=8'h5A with `tx_data_valid`, then 8'hA5 after the first `tx_busy` fall;
  - `sched_busy` drops after the second fall.
- req_a and req_b raised together after reset, both one-byte, data 16'h0011 and 16'h0022:
  - 8'h11 sent first, then 8'h22.
  - Repeat the contention: B now wins (8'h22 then 8'h11).
- req_b raised during the WAIT_LO of an A transfer: no `gnt_b` until IDLE; then `gnt_b` and B's byte follows.
- Assert rst=0 for one cycle during WAIT_LO of byte 0 of a two-byte transfer: all outputs 0, state IDLE, second byte never sent.
- `tx_busy` held high in IDLE with req_a=1: no grant until `tx_busy`=0.
- With the macro and WD_CYCLES=8, `tx_busy` stuck at 0 after `tx_data_valid`: `err_timeout`=1 after 8 cycles, FSM back in IDLE, second byte dropped. Without the macro: FSM stays in WAIT_HI.

Source files
------------

// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the UART TX scheduler.
// Optional feature macro: UART_TX_SCHED_WDOG_EN (adds the ABORT state).
package uart_tx_sched_pkg;

    localparam int   BYTE_W = 8;
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEND    = 3'd1,
        ST_WAIT_HI = 3'd2,
`ifdef UART_TX_SCHED_WDOG_EN
        ST_WAIT_LO = 3'd3,
        ST_ABORT   = 3'd4
`else
        ST_WAIT_LO = 3'd3
`endif
    } sched_state_e;

    // Pick byte 0 (low) or byte 1 (high) of a latched two-byte word.
    function automatic logic [BYTE_W-1:0] sel_byte(input logic [2*BYTE_W-1:0] word,
                                                   input logic                idx);
        logic [BYTE_W-1:0] b;
        if (idx) begin
            b = word[2*BYTE_W-1:BYTE_W];
        end else begin
            b = word[BYTE_W-1:0];
        end
        return b;
    endfunction

endpackage

// File: rtl/tx_rr_arb.sv
// Two-input round-robin arbiter. The grant is combinational so the caller
// can latch data on the same edge; the last-winner pointer is internal.
module tx_rr_arb
    import uart_tx_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic [1:0] gnt
);

    logic       last_r;
    logic [1:0] gnt_s;

    // Choose the winner; on contention the port that did not win last time goes first.
    always_comb begin
        gnt_s = 2'b00;
        if (grant_en) begin
            case (req)
                2'b01:   gnt_s = 2'b01;
                2'b10:   gnt_s = 2'b10;
                2'b11:   gnt_s = (last_r == PORT_B) ? 2'b01 : 2'b10;
                default: gnt_s = 2'b00;
            endcase
        end else begin
            gnt_s = 2'b00;
        end
    end

    assign gnt = gnt_s;

    // Remember the last winner; only an actual grant moves the pointer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_r <= PORT_B;
        end else if (gnt_s[PORT_A]) begin
            last_r <= PORT_A;
        end else if (gnt_s[PORT_B]) begin
            last_r <= PORT_B;
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between two requesters, sending each granted
// word LSB byte first and pacing on the transmitter's BUSY.
// Optional feature macro: UART_TX_SCHED_WDOG_EN (BUSY watchdog + ABORT state).
module uart_tx_scheduler
    import uart_tx_sched_pkg::*;
#(
    parameter int WORD_W    = 16,
    parameter int WD_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_a,
    input  logic [WORD_W-1:0] data_a,
    input  logic              two_a,
    output logic              gnt_a,
    input  logic              req_b,
    input  logic [WORD_W-1:0] data_b,
    input  logic              two_b,
    output logic              gnt_b,
    input  logic              tx_busy,
    output logic [7:0]        tx_p_data,
    output logic              tx_data_valid,
    output logic              sched_busy,
    output logic              err_timeout
);

    if (!(WORD_W == 8 || WORD_W == 16) || WD_CYCLES < 1) begin : g_bad_cfg
        $error("uart_tx_scheduler: WORD_W must be 8 or 16 and WD_CYCLES at least 1");
    end

    // A narrow requester can never ask for a second byte.
    localparam logic WIDE = (WORD_W == 16);

    sched_state_e        state_r;
    logic [2*BYTE_W-1:0] word_r;
    logic                two_r;
    logic                idx_r;
    logic                gnt_a_r;
    logic                gnt_b_r;
    logic [BYTE_W-1:0]   tx_p_data_r;
    logic                tx_dv_r;
    logic                sched_busy_r;
    logic                err_r;
    logic [1:0]          arb_gnt_s;
    logic                grant_en_s;

`ifdef UART_TX_SCHED_WDOG_EN
    localparam int unsigned WD_LO_LIM = 32'd176 * WD_CYCLES;
    localparam int          WD_W      = $clog2(WD_LO_LIM + 32'd1);
    logic [WD_W-1:0] wd_cnt_r;
`endif

    assign grant_en_s = (state_r == ST_IDLE) && !tx_busy;

    tx_rr_arb u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      ({req_b, req_a}),
        .grant_en (grant_en_s),
        .gnt      (arb_gnt_s)
    );

    // Scheduler FSM: grant, present byte, then wait for BUSY to rise and fall.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            word_r       <= 16'h0000;
            two_r        <= 1'b0;
            idx_r        <= 1'b0;
            gnt_a_r      <= 1'b0;
            gnt_b_r      <= 1'b0;
            tx_p_data_r  <= 8'h00;
            tx_dv_r      <= 1'b0;
            sched_busy_r <= 1'b0;
            err_r        <= 1'b0;
`ifdef UART_TX_SCHED_WDOG_EN
            wd_cnt_r     <= '0;
`endif
        end else begin
            gnt_a_r <= 1'b0;
            gnt_b_r <= 1'b0;
            tx_dv_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (arb_gnt_s[PORT_A]) begin
                        word_r       <= 16'(data_a);
                        two_r        <= two_a & WIDE;
                        tx_p_data_r  <= data_a[7:0];
                        gnt_a_r      <= 1'b1;
                        idx_r        <= 1'b0;
                        tx_dv_r      <= 1'b1;
                        sched_busy_r <= 1'b1;
                        state_r      <= ST_SEND;
                    end else if (arb_gnt_s[PORT_B]) begin
                        word_r       <= 16'(data_b);
                        two_r        <= two_b & WIDE;
                        tx_p_data_r  <= data_b[7:0];
                        gnt_b_r      <= 1'b1;
                        idx_r        <= 1'b0;
                        tx_dv_r      <= 1'b1;
                        sched_busy_r <= 1'b1;
                        state_r      <= ST_SEND;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SEND: begin
                    state_r <= ST_WAIT_HI;
`ifdef UART_TX_SCHED_WDOG_EN
                    wd_cnt_r <= '0;
`endif
                end
                ST_WAIT_HI: begin
                    if (tx_busy) begin
                        state_r <= ST_WAIT_LO;
`ifdef UART_TX_SCHED_WDOG_EN
                        wd_cnt_r <= '0;
                    end else if (wd_cnt_r == WD_W'(WD_CYCLES - 1)) begin
                        state_r <= ST_ABORT;
                        err_r   <= 1'b1;
                    end else begin
                        wd_cnt_r <= wd_cnt_r + 1'b1;
`else
                    end else begin
                        state_r <= ST_WAIT_HI;
`endif
                    end
                end
                ST_WAIT_LO: begin
                    if (!tx_busy) begin
                        if (!idx_r && two_r) begin
                            idx_r       <= 1'b1;
                            tx_p_data_r <= sel_byte(word_r, 1'b1);
                            tx_dv_r     <= 1'b1;
                            state_r     <= ST_SEND;
                        end else begin
                            sched_busy_r <= 1'b0;
                            state_r      <= ST_IDLE;
                        end
`ifdef UART_TX_SCHED_WDOG_EN
                    end else if (wd_cnt_r == WD_W'(WD_LO_LIM - 1)) begin
                        state_r <= ST_ABORT;
                        err_r   <= 1'b1;
                    end else begin
                        wd_cnt_r <= wd_cnt_r + 1'b1;
`else
                    end else begin
                        state_r <= ST_WAIT_LO;
`endif
                    end
                end
`ifdef UART_TX_SCHED_WDOG_EN
                ST_ABORT: begin
                    sched_busy_r <= 1'b0;
                    state_r      <= ST_IDLE;
                end
`endif
                default: begin
                    sched_busy_r <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt_a         = gnt_a_r;
    assign gnt_b         = gnt_b_r;
    assign tx_p_data     = tx_p_data_r;
    assign tx_data_valid = tx_dv_r;
    assign sched_busy    = sched_busy_r;
    assign err_timeout   = err_r;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: directed timing steps plus
// randomized rounds checked against a transaction-level reference model.
module tb_uart_tx_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_a = 1'b0, req_b = 1'b0;
    logic [15:0] data_a = 16'h0000, data_b = 16'h0000;
    logic        two_a = 1'b0, two_b = 1'b0;
    logic        gnt_a, gnt_b;
    logic        tx_busy;
    logic [7:0]  tx_p_data;
    logic        tx_data_valid;
    logic        sched_busy;
    logic        err_timeout;

    // transmitter emulation / monitor state
    bit          auto_tx = 1'b0;
    logic        man_busy = 1'b0;
    logic        model_busy = 1'b0;
    int          busy_cnt = 0;
    int          frame_len = 4;
    logic [7:0]  hold_byte = 8'h00;
    int          unstable = 0;
    int          dbl_gnt = 0;
    logic        prev_gnt_a = 1'b0, prev_gnt_b = 1'b0;
    logic [7:0]  cap_q[$];
    logic        gord_q[$];

    // reference model state: port that won the last grant (1 = B)
    logic        mdl_last = 1'b1;

    int total = 0;
    int bad = 0;

    assign tx_busy = auto_tx ? model_busy : man_busy;

    always #5 clk = ~clk;

    uart_tx_scheduler #(.WORD_W(16), .WD_CYCLES(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_a         (req_a),
        .data_a        (data_a),
        .two_a         (two_a),
        .gnt_a         (gnt_a),
        .req_b         (req_b),
        .data_b        (data_b),
        .two_b         (two_b),
        .gnt_b         (gnt_b),
        .tx_busy       (tx_busy),
        .tx_p_data     (tx_p_data),
        .tx_data_valid (tx_data_valid),
        .sched_busy    (sched_busy),
        .err_timeout   (err_timeout)
    );

    // Monitor plus a simple transmitter: BUSY high for frame_len cycles after each start.
    always @(negedge clk) begin
        if (gnt_a === 1'b1) begin
            gord_q.push_back(1'b0);
            if (prev_gnt_a === 1'b1) dbl_gnt++;
        end
        if (gnt_b === 1'b1) begin
            gord_q.push_back(1'b1);
            if (prev_gnt_b === 1'b1) dbl_gnt++;
        end
        prev_gnt_a = gnt_a;
        prev_gnt_b = gnt_b;
        if (tx_data_valid === 1'b1) cap_q.push_back(tx_p_data);
        if (auto_tx) begin
            if (tx_data_valid === 1'b1) begin
                hold_byte = tx_p_data;
                busy_cnt  = frame_len;
            end else if (busy_cnt > 0) begin
                if (tx_p_data !== hold_byte) unstable++;
                busy_cnt--;
            end
        end else begin
            busy_cnt = 0;
        end
        model_busy = (busy_cnt > 0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Called in the SEND cycle: BUSY pulse of two cycles; returns one cycle after the fall.
    task automatic finish_byte();
        man_busy = 1'b1;
        step();
        step();
        man_busy = 1'b0;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        mdl_last = 1'b1;
    endtask

    // One transaction round in auto-transmitter mode, checked against the model.
    task automatic do_round(input logic ra, input logic rb, input logic [15:0] da,
                            input logic [15:0] db, input logic ta, input logic tb,
                            input string tag);
        logic [7:0] exp_q[$];
        logic       exp_g[$];
        logic       first;
        logic       p;
        bit         done;
        logic [7:0] got;
        if (ra && rb) first = (mdl_last == 1'b1) ? 1'b0 : 1'b1;
        else          first = ra ? 1'b0 : 1'b1;
        for (int k = 0; k < 2; k++) begin
            p = (k == 0) ? first : ~first;
            if ((p == 1'b0 && ra) || (p == 1'b1 && rb)) begin
                exp_g.push_back(p);
                exp_q.push_back(p ? db[7:0] : da[7:0]);
                if (p ? tb : ta) exp_q.push_back(p ? db[15:8] : da[15:8]);
                mdl_last = p;
            end
        end
        cap_q.delete();
        gord_q.delete();
        req_a = ra; data_a = da; two_a = ta;
        req_b = rb; data_b = db; two_b = tb;
        done = 1'b0;
        for (int n = 0; n < 400; n++) begin
            step();
            if (gnt_a === 1'b1) req_a = 1'b0;
            if (gnt_b === 1'b1) req_b = 1'b0;
            if (!req_a && !req_b && sched_busy === 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        req_a = 1'b0;
        req_b = 1'b0;
        chk({tag, "_nbytes"}, cap_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < cap_q.size()) ? cap_q[i] : 8'hxx;
            chk($sformatf("%s_byte%0d", tag, i), 32'(got), 32'(exp_q[i]));
        end
        chk({tag, "_ngnt"}, gord_q.size(), exp_g.size());
        chk({tag, "_gnt0"}, 32'(gord_q.size() > 0 ? gord_q[0] : 1'bx), 32'(exp_g[0]));
        step();
    endtask

    initial begin
        logic       ra, rb, ta, tb;
        logic [15:0] da, db;
        bit          seen;

        // reset state
        do_reset();
        chk("rst_gnt_a", 32'(gnt_a), 32'd0);
        chk("rst_gnt_b", 32'(gnt_b), 32'd0);
        chk("rst_p_data", 32'(tx_p_data), 32'd0);
        chk("rst_dv", 32'(tx_data_valid), 32'd0);
        chk("rst_sched_busy", 32'(sched_busy), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);

        // contention after reset, then repeated
        auto_tx = 1'b1;
        frame_len = 4;
        do_round(1'b1, 1'b1, 16'h0011, 16'h0022, 1'b0, 1'b0, "cont1");
        do_round(1'b1, 1'b1, 16'h0011, 16'h0022, 1'b0, 1'b0, "cont2");
        auto_tx = 1'b0;
        step();

        // single port A, two bytes, exact timing
        cap_q.delete();
        gord_q.delete();
        req_a = 1'b1; data_a = 16'hA55A; two_a = 1'b1;
        step();
        chk("t1_gnt_a", 32'(gnt_a), 32'd1);
        chk("t1_dv0", 32'(tx_data_valid), 32'd1);
        chk("t1_byte0", 32'(tx_p_data), 32'h5A);
        chk("t1_busy0", 32'(sched_busy), 32'd1);
        req_a = 1'b0;
        step();
        chk("t1_gnt_a_off", 32'(gnt_a), 32'd0);
        chk("t1_dv0_off", 32'(tx_data_valid), 32'd0);
        man_busy = 1'b1;
        step();
        step();
        chk("t1_hold", 32'(tx_p_data), 32'h5A);
        man_busy = 1'b0;
        step();
        chk("t1_dv1", 32'(tx_data_valid), 32'd1);
        chk("t1_byte1", 32'(tx_p_data), 32'hA5);
        finish_byte();
        chk("t1_idle", 32'(sched_busy), 32'd0);
        chk("t1_ngnt", gord_q.size(), 32'd1);
        mdl_last = 1'b0;

        // req_b raised while A waits for BUSY to fall
        req_a = 1'b1; data_a = 16'h0033; two_a = 1'b0;
        step();
        chk("t3_gnt_a", 32'(gnt_a), 32'd1);
        req_a = 1'b0;
        man_busy = 1'b1;
        step();
        step();
        req_b = 1'b1; data_b = 16'h0044; two_b = 1'b0;
        step();
        chk("t3_no_gnt_b_lo", 32'(gnt_b), 32'd0);
        man_busy = 1'b0;
        step();
        chk("t3_no_gnt_b_idle", 32'(gnt_b), 32'd0);
        chk("t3_idle_gap", 32'(sched_busy), 32'd0);
        step();
        chk("t3_gnt_b", 32'(gnt_b), 32'd1);
        chk("t3_dv", 32'(tx_data_valid), 32'd1);
        chk("t3_byte_b", 32'(tx_p_data), 32'h44);
        req_b = 1'b0;
        finish_byte();
        chk("t3_done", 32'(sched_busy), 32'd0);
        mdl_last = 1'b1;

        // reset during WAIT_LO of byte 0 of a two-byte transfer
        req_a = 1'b1; data_a = 16'hBEEF; two_a = 1'b1;
        step();
        chk("t4_gnt_a", 32'(gnt_a), 32'd1);
        req_a = 1'b0;
        man_busy = 1'b1;
        step();
        step();
        cap_q.delete();
        rst = 1'b0;
        step();
        chk("t4_rst_p_data", 32'(tx_p_data), 32'd0);
        chk("t4_rst_dv", 32'(tx_data_valid), 32'd0);
        chk("t4_rst_busy", 32'(sched_busy), 32'd0);
        chk("t4_rst_gnt", 32'({gnt_a, gnt_b}), 32'd0);
        rst = 1'b1;
        mdl_last = 1'b1;
        man_busy = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("t4_no_byte1", cap_q.size(), 32'd0);

        // BUSY high in IDLE blocks the grant
        man_busy = 1'b1;
        gord_q.delete();
        req_a = 1'b1; data_a = 16'h005C; two_a = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("t5_no_gnt", gord_q.size(), 32'd0);
        chk("t5_idle", 32'(sched_busy), 32'd0);
        man_busy = 1'b0;
        step();
        chk("t5_gnt_a", 32'(gnt_a), 32'd1);
        chk("t5_byte", 32'(tx_p_data), 32'h5C);
        req_a = 1'b0;
        finish_byte();
        mdl_last = 1'b0;

        // BUSY stuck low after a start
        cap_q.delete();
        req_a = 1'b1; data_a = 16'h1234; two_a = 1'b1;
        step();
        req_a = 1'b0;
`ifdef UART_TX_SCHED_WDOG_EN
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (err_timeout === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("wd_err_set", 32'(seen), 32'd1);
        step();
        step();
        chk("wd_idle", 32'(sched_busy), 32'd0);
        chk("wd_sticky", 32'(err_timeout), 32'd1);
`else
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (err_timeout !== 1'b0) seen = 1'b1;
        end
        chk("wd_no_err", 32'(seen), 32'd0);
        chk("wd_stuck", 32'(sched_busy), 32'd1);
`endif
        chk("wd_one_byte", cap_q.size(), 32'd1);
        do_reset();
        chk("wd_err_cleared", 32'(err_timeout), 32'd0);

        // randomized rounds
        auto_tx = 1'b1;
        for (int r = 0; r < 24; r++) begin
            ra = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            if (!ra && !rb) ra = 1'b1;
            da = 16'($urandom);
            db = 16'($urandom);
            ta = 1'($urandom_range(0, 1));
            tb = 1'($urandom_range(0, 1));
            frame_len = $urandom_range(2, 8);
            do_round(ra, rb, da, db, ta, tb, $sformatf("rnd%0d", r));
        end

        chk("no_double_gnt", dbl_gnt, 32'd0);
        chk("p_data_stable", unstable, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
